vdp_sprite_pixel_buffer: RTL

- Downstream consumer of the VDP sprite fetch/interface stage.
- Captures the 4-byte pattern rows that stage reads out of VRAM for up to 8 sprites on the current scanline, into per-slot 8-row × 4-plane buffers.
- During active display it serialises them into one 4-bit sprite colour index per pixel, with fixed slot priority, transparency and a sticky collision flag.
- Output feeds the VDP pixel mux / CRAM lookup.

---
 rtl/vdp_sprite_pixel_buffer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/vdp_sprite_pixel_buffer.sv
// Sprite pixel buffer: captures per-slot pattern rows from the sprite fetch stage and
// serialises them into one colour index per display pixel with fixed slot priority,
// transparency and a sticky collision flag. Read path is a 2-stage pipeline.
module vdp_sprite_pixel_buffer #(
  parameter int unsigned NUM_SPR = 8,
  parameter int unsigned ROWS    = 8
) (
  input  logic                    i_clk,
  input  logic                    i_rst_L,
  input  logic                    i_line_clr,
  input  logic                    i_wr_en,
  input  logic [2:0]              i_wr_slot,
  input  logic [2:0]              i_wr_row,
  input  logic [3:0][7:0]         i_wr_data,
  input  logic                    i_slot_commit,
  input  logic [NUM_SPR-1:0][7:0] i_hpos,
  input  logic [NUM_SPR-1:0][2:0] i_row_sel,
  input  logic                    i_pix_req,
  input  logic [7:0]              i_pix_x,
  input  logic                    i_stat_rd,
  output logic [NUM_SPR-1:0]      o_slot_loaded,
  output logic                    o_pix_valid,
  output logic [3:0]              o_pix_color,
  output logic [2:0]              o_pix_slot,
  output logic                    o_collision
);

  // Pattern storage: [slot][row] -> four bitplanes of one 8-pixel row
  logic [3:0][7:0] r_buf [NUM_SPR][ROWS];

  logic [NUM_SPR-1:0] r_slot_loaded;

  // Stage 1 registers
  logic               r_s1_vld;
  logic [NUM_SPR-1:0] r_s1_opaque;
  logic [3:0]         r_s1_col [NUM_SPR];

  // Stage 2 (output) registers
  logic       r_pix_valid;
  logic [3:0] r_pix_color;
  logic [2:0] r_pix_slot;
  logic       r_collision;

  // Stage 1 combinational decode
  logic [8:0]      w_diff   [NUM_SPR];
  logic [2:0]      w_idx    [NUM_SPR];
  logic [3:0][7:0] w_row    [NUM_SPR];
  logic [3:0]      w_col    [NUM_SPR];
  logic [NUM_SPR-1:0] w_opaque;

  // Stage 2 priority resolution
  logic       w_any;
  logic       w_multi;
  logic [3:0] w_win_col;
  logic [2:0] w_win_slot;

  // Pattern row write; buffer contents need no reset
  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_buf[i_wr_slot][i_wr_row] <= i_wr_data;
    end
  end

  // Slot committed flags; line_clr overrides a same-cycle commit
  always_ff @(posedge i_clk) begin
    if (!i_rst_L) begin
      r_slot_loaded <= '0;
    end else if (i_line_clr) begin
      r_slot_loaded <= '0;
    end else if (i_slot_commit) begin
      r_slot_loaded[i_wr_slot] <= 1'b1;
    end
  end

  // Per-slot hit test and colour fetch; 9-bit difference so sprites do not wrap at x=255
  always_comb begin
    for (int i = 0; i < NUM_SPR; i++) begin
      w_diff[i]   = {1'b0, i_pix_x} - {1'b0, i_hpos[i]};
      w_idx[i]    = 3'd7 - w_diff[i][2:0];
      w_row[i]    = r_buf[i][i_row_sel[i]];
      w_col[i]    = {w_row[i][3][w_idx[i]], w_row[i][2][w_idx[i]],
                     w_row[i][1][w_idx[i]], w_row[i][0][w_idx[i]]};
      w_opaque[i] = r_slot_loaded[i] && !w_diff[i][8] && (w_diff[i][7:3] == 5'd0) &&
                    (w_col[i] != 4'd0);
    end
  end

  // Stage 1 control registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_L) begin
      r_s1_vld    <= 1'b0;
      r_s1_opaque <= '0;
    end else begin
      r_s1_vld    <= i_pix_req;
      r_s1_opaque <= i_pix_req ? w_opaque : '0;
    end
  end

  // Stage 1 colour data registers
  always_ff @(posedge i_clk) begin
    for (int i = 0; i < NUM_SPR; i++) begin
      r_s1_col[i] <= w_col[i];
    end
  end

  // Lowest-index opaque slot wins; a second opaque slot flags an overlap
  always_comb begin
    w_any      = 1'b0;
    w_multi    = 1'b0;
    w_win_col  = 4'd0;
    w_win_slot = 3'd0;
    for (int i = 0; i < NUM_SPR; i++) begin
      if (r_s1_opaque[i]) begin
        if (w_any) begin
          w_multi = 1'b1;
        end else begin
          w_any      = 1'b1;
          w_win_col  = r_s1_col[i];
          w_win_slot = 3'(i);
        end
      end
    end
  end

  // Stage 2 output registers; collision set beats a same-cycle status read
  always_ff @(posedge i_clk) begin
    if (!i_rst_L) begin
      r_pix_valid <= 1'b0;
      r_pix_color <= 4'd0;
      r_pix_slot  <= 3'd0;
      r_collision <= 1'b0;
    end else begin
      r_pix_valid <= r_s1_vld && w_any;
      r_pix_color <= (r_s1_vld && w_any) ? w_win_col : 4'd0;
      r_pix_slot  <= (r_s1_vld && w_any) ? w_win_slot : 3'd0;
      if (r_s1_vld && w_multi) begin
        r_collision <= 1'b1;
      end else if (i_stat_rd) begin
        r_collision <= 1'b0;
      end
    end
  end

  assign o_slot_loaded = r_slot_loaded;
  assign o_pix_valid   = r_pix_valid;
  assign o_pix_color   = r_pix_color;
  assign o_pix_slot    = r_pix_slot;
  assign o_collision   = r_collision;

endmodule
